// File: rtl/mem_access_unit_if.sv
// Data-memory port of the MEM stage: registered request side driven by the
// access unit, ready/read-data returned by the memory.
interface mem_access_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ready,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ready,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage controller: turns EX/MEM loads/stores into a req/ready memory
// handshake, stalls the pipeline while busy, and holds the MEM/WB register.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          ctrl_wb_in,
    input  logic                mem_write_in,
    input  logic                mem_read_in,
    input  logic [31:0]         alu_result_in,
    input  logic [31:0]         wdata_in,
    input  logic [4:0]          rd_in,
    mem_access_unit_if.master   dmem,
    output logic                stall,
    output logic [1:0]          ctrl_wb_out,
    output logic [31:0]         mem_rdata_out,
    output logic [31:0]         alu_result_out,
    output logic [4:0]          rd_out,
    output logic                misalign_err,
    output logic                bus_err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_reg, state_next;
    logic          req_reg, req_next;
    logic          we_reg, we_next;
    logic [31:0]   addr_reg, addr_next;
    logic [31:0]   wdata_reg, wdata_next;
    logic [1:0]    cap_ctrl_reg, cap_ctrl_next;
    logic [31:0]   cap_alu_reg, cap_alu_next;
    logic [4:0]    cap_rd_reg, cap_rd_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [1:0]    ctrl_out_reg, ctrl_out_next;
    logic [31:0]   rdata_out_reg, rdata_out_next;
    logic [31:0]   alu_out_reg, alu_out_next;
    logic [4:0]    rd_out_reg, rd_out_next;
    logic          mis_reg, mis_next;
    logic          berr_reg, berr_next;
    logic          stall_next;

    logic access;
    logic aligned;

    assign access  = mem_read_in | mem_write_in;
    assign aligned = (alu_result_in[1:0] == 2'b00);

    always_comb begin
        state_next     = state_reg;
        req_next       = req_reg;
        we_next        = we_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        cap_ctrl_next  = cap_ctrl_reg;
        cap_alu_next   = cap_alu_reg;
        cap_rd_next    = cap_rd_reg;
        cnt_next       = cnt_reg;
        ctrl_out_next  = ctrl_out_reg;
        rdata_out_next = rdata_out_reg;
        alu_out_next   = alu_out_reg;
        rd_out_next    = rd_out_reg;
        mis_next       = 1'b0;
        berr_next      = 1'b0;
        stall_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (access && aligned) begin
                    // Store wins when both strobes are set.
                    stall_next    = 1'b1;
                    req_next      = 1'b1;
                    we_next       = mem_write_in;
                    addr_next     = alu_result_in;
                    wdata_next    = wdata_in;
                    cap_ctrl_next = ctrl_wb_in;
                    cap_alu_next  = alu_result_in;
                    cap_rd_next   = rd_in;
                    cnt_next      = '0;
                    ctrl_out_next = 2'b00;
                    state_next    = BUSY;
                end else if (access) begin
                    mis_next      = 1'b1;
                    ctrl_out_next = 2'b00;
                    alu_out_next  = alu_result_in;
                    rd_out_next   = rd_in;
                end else begin
                    ctrl_out_next = ctrl_wb_in;
                    alu_out_next  = alu_result_in;
                    rd_out_next   = rd_in;
                end
            end
            BUSY: begin
                stall_next = !dmem.dmem_ready;
                if (dmem.dmem_ready) begin
                    ctrl_out_next = cap_ctrl_reg;
                    alu_out_next  = cap_alu_reg;
                    rd_out_next   = cap_rd_reg;
                    if (!we_reg) begin
                        rdata_out_next = dmem.dmem_rdata;
                    end
                    req_next   = 1'b0;
                    state_next = IDLE;
                end else if (cnt_reg == CW'(TIMEOUT_CYCLES - 1)) begin
                    // Abort: drop the request and retire a bubble.
                    berr_next     = 1'b1;
                    req_next      = 1'b0;
                    ctrl_out_next = 2'b00;
                    state_next    = IDLE;
                end else begin
                    cnt_next      = cnt_reg + CW'(1);
                    ctrl_out_next = 2'b00;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            req_reg       <= 1'b0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            cap_ctrl_reg  <= '0;
            cap_alu_reg   <= '0;
            cap_rd_reg    <= '0;
            cnt_reg       <= '0;
            ctrl_out_reg  <= '0;
            rdata_out_reg <= '0;
            alu_out_reg   <= '0;
            rd_out_reg    <= '0;
            mis_reg       <= 1'b0;
            berr_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            req_reg       <= req_next;
            we_reg        <= we_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            cap_ctrl_reg  <= cap_ctrl_next;
            cap_alu_reg   <= cap_alu_next;
            cap_rd_reg    <= cap_rd_next;
            cnt_reg       <= cnt_next;
            ctrl_out_reg  <= ctrl_out_next;
            rdata_out_reg <= rdata_out_next;
            alu_out_reg   <= alu_out_next;
            rd_out_reg    <= rd_out_next;
            mis_reg       <= mis_next;
            berr_reg      <= berr_next;
        end
    end

    // Reset puts the FSM in IDLE immediately; mask stall so it reads 0 too.
    assign stall           = stall_next & rst_n;
    assign dmem.dmem_req   = req_reg;
    assign dmem.dmem_we    = we_reg;
    assign dmem.dmem_addr  = addr_reg;
    assign dmem.dmem_wdata = wdata_reg;
    assign ctrl_wb_out     = ctrl_out_reg;
    assign mem_rdata_out   = rdata_out_reg;
    assign alu_result_out  = alu_out_reg;
    assign rd_out          = rd_out_reg;
    assign misalign_err    = mis_reg;
    assign bus_err         = berr_reg;
endmodule
